// File: rtl/prb_scan_controller_pkg.sv
// Shared definitions for the convolution scan controller: FSM state encoding and
// default array geometry.
package prb_scan_controller_pkg;

    localparam int unsigned DefInputWidth    = 4;
    localparam int unsigned DefInputWidthLog = 2;
    localparam int unsigned DefKernelWidth   = 3;
    localparam int unsigned DefKernelHeight  = 3;
    localparam int unsigned DefRowW          = 8;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StIssue,
        StWait,
        StCommit,
        StDone
    } scan_state_e;

endpackage

// File: rtl/prb_scan_controller_counter.sv
// Nested column/row counter for the scan: column wraps at the row end, row stops at
// the last latched row.
module prb_scan_counter #(
    parameter int unsigned INPUT_WIDTH     = 4,
    parameter int unsigned INPUT_WIDTH_LOG = 2,
    parameter int unsigned ROW_W           = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       advance_i,
    input  logic [ROW_W-1:0]           last_row_idx_i,
    output logic [INPUT_WIDTH_LOG-1:0] col_o,
    output logic [ROW_W-1:0]           row_o,
    output logic                       last_col_o,
    output logic                       last_row_o
);

    localparam logic [INPUT_WIDTH_LOG-1:0] ColLast = INPUT_WIDTH_LOG'(INPUT_WIDTH - 1);

    logic [INPUT_WIDTH_LOG-1:0] col_q, col_d;
    logic [ROW_W-1:0]           row_q, row_d;

    assign last_col_o = (col_q == ColLast);
    assign last_row_o = (row_q == last_row_idx_i);
    assign col_o      = col_q;
    assign row_o      = row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (advance_i) begin
            if (last_col_o) begin
                col_d = '0;
                // On the final column of the final row the row index is left in place.
                if (!last_row_o) begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + INPUT_WIDTH_LOG'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/prb_scan_controller.sv
// Layer-pass sequencer: walks rows and columns, handshakes each column with the MAC
// array and strobes the partial result buffer.
module prb_scan_controller
    import prb_scan_controller_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH     = DefInputWidth,
    parameter int unsigned INPUT_WIDTH_LOG = DefInputWidthLog,
    parameter int unsigned KERNEL_WIDTH    = DefKernelWidth,
    parameter int unsigned KERNEL_HEIGHT   = DefKernelHeight,
    parameter int unsigned ROW_W           = DefRowW
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ROW_W-1:0]           num_rows,
    input  logic                       mac_done,
    output logic                       col_req,
    output logic [INPUT_WIDTH_LOG-1:0] width_index,
    output logic [ROW_W-1:0]           row_index,
    output logic                       buf_clear,
    output logic                       buf_enable,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       done
);

    localparam logic [INPUT_WIDTH_LOG-1:0] KwLast = INPUT_WIDTH_LOG'(KERNEL_WIDTH - 1);
    localparam logic [ROW_W-1:0]           KhLast = ROW_W'(KERNEL_HEIGHT - 1);

    scan_state_e      state_q, state_d;
    logic [ROW_W-1:0] num_rows_q, num_rows_d;
    logic             cnt_clear, cnt_advance;
    logic             last_col, last_row;

    prb_scan_counter #(
        .INPUT_WIDTH    (INPUT_WIDTH),
        .INPUT_WIDTH_LOG(INPUT_WIDTH_LOG),
        .ROW_W          (ROW_W)
    ) u_counter (
        .clk_i         (clock),
        .rst_i         (reset),
        .clear_i       (cnt_clear),
        .advance_i     (cnt_advance),
        .last_row_idx_i(num_rows_q - ROW_W'(1)),
        .col_o         (width_index),
        .row_o         (row_index),
        .last_col_o    (last_col),
        .last_row_o    (last_row)
    );

    always_comb begin
        state_d     = state_q;
        num_rows_d  = num_rows_q;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    num_rows_d = num_rows;
                    cnt_clear  = 1'b1;
                    state_d    = StClear;
                end
            end
            StClear:  state_d = (num_rows_q == '0) ? StDone : StIssue;
            StIssue:  state_d = StWait;
            StWait: begin
                if (mac_done) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                cnt_advance = 1'b1;
                state_d     = (last_col && last_row) ? StDone : StIssue;
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            num_rows_q <= '0;
        end else begin
            state_q    <= state_d;
            num_rows_q <= num_rows_d;
        end
    end

    always_comb begin
        col_req    = (state_q == StIssue);
        buf_clear  = (state_q == StClear);
        buf_enable = (state_q == StCommit) && (width_index >= KwLast);
        out_valid  = buf_enable && (row_index >= KhLast);
        busy       = (state_q != StIdle);
        done       = (state_q == StDone);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert ($onehot0({col_req, buf_clear, buf_enable, done}));
            assert (!buf_enable || (state_q == StCommit));
        end
    end

endmodule

// File: tb/tb_prb_scan_controller.sv
// Directed bench for prb_scan_controller with IW=4, KW=KH=3.
module tb_prb_scan_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] num_rows;
    logic       mac_done;
    logic       col_req;
    logic [1:0] width_index;
    logic [7:0] row_index;
    logic       buf_clear;
    logic       buf_enable;
    logic       out_valid;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    prb_scan_controller #(
        .INPUT_WIDTH    (4),
        .INPUT_WIDTH_LOG(2),
        .KERNEL_WIDTH   (3),
        .KERNEL_HEIGHT  (3),
        .ROW_W          (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .num_rows   (num_rows),
        .mac_done   (mac_done),
        .col_req    (col_req),
        .width_index(width_index),
        .row_index  (row_index),
        .buf_clear  (buf_clear),
        .buf_enable (buf_enable),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int outs_word();
        return {col_req, buf_clear, buf_enable, out_valid, busy, done, width_index, row_index};
    endfunction

    // One pass: start in the first idle cycle, answer each col_req after `stall` cycles.
    // Cycle 1 is the first cycle after the edge that accepts start.
    task automatic run_pass(input logic [7:0] rows, input int stall,
                            output int n_req, output int n_en, output int n_ov,
                            output int clear_cyc, output int first_req_cyc,
                            output int done_cyc, output int en_bad, output int final_row,
                            output int first_req_w);
        int req_cyc;
        n_req = 0; n_en = 0; n_ov = 0; en_bad = 0;
        clear_cyc = -1; first_req_cyc = -1; done_cyc = -1; final_row = -1;
        first_req_w = -1; req_cyc = -100;
        @(negedge clock);
        start    = 1'b1;
        num_rows = rows;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clock);
            start    = 1'b0;
            mac_done = (cyc == req_cyc + stall);
            if (buf_clear) clear_cyc = cyc;
            if (col_req) begin
                n_req++;
                req_cyc = cyc;
                if (first_req_cyc < 0) begin
                    first_req_cyc = cyc;
                    first_req_w   = {width_index, row_index};
                end
            end
            if (buf_enable) begin
                n_en++;
                if (width_index < 2) en_bad++;
            end
            if (out_valid) begin
                n_ov++;
                if (row_index != 8'd2) en_bad++;
            end
            if (done) begin
                done_cyc  = cyc;
                final_row = {width_index, row_index};
                break;
            end
        end
        mac_done = 1'b0;
    endtask

    initial begin
        int n_req, n_en, n_ov, clear_cyc, first_req_cyc, done_cyc, en_bad, final_row, frw;
        int n_done;
        int a_req, a_en, a_ov, a_done;
        logic [1:0] w0;

        reset = 1'b1; start = 1'b0; num_rows = 8'd0; mac_done = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_outputs", outs_word(), 0);
        reset = 1'b0;

        // Reset during WAIT aborts the pass without a done pulse.
        start = 1'b1; num_rows = 8'd3;
        @(negedge clock); start = 1'b0;            // CLEAR
        @(negedge clock);                          // ISSUE
        check("abort_issue_req", int'(col_req), 1);
        @(negedge clock);                          // WAIT
        check("abort_wait_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clock);
        check("abort_outputs_zero", outs_word(), 0);
        reset = 1'b0;
        n_done = 0;
        repeat (5) begin
            @(negedge clock);
            if (done || busy) n_done++;
        end
        check("abort_no_done", n_done, 0);

        // Full pass, 3 rows, MAC answers 2 cycles after each request.
        run_pass(8'd3, 2, n_req, n_en, n_ov, clear_cyc, first_req_cyc, done_cyc, en_bad,
                 final_row, frw);
        check("full_clear_cyc", clear_cyc, 1);
        check("full_first_req_cyc", first_req_cyc, 2);
        check("full_first_req_pos", frw, 0);
        check("full_n_req", n_req, 12);
        check("full_n_en", n_en, 6);
        check("full_n_ov", n_ov, 2);
        check("full_en_cols", en_bad, 0);
        check("full_done_cyc", done_cyc, 50);
        check("full_final_pos", final_row, 2);
        a_req = n_req; a_en = n_en; a_ov = n_ov; a_done = done_cyc;

        // Back-to-back: start in the idle cycle right after done.
        run_pass(8'd3, 2, n_req, n_en, n_ov, clear_cyc, first_req_cyc, done_cyc, en_bad,
                 final_row, frw);
        check("b2b_first_req_pos", frw, 0);
        check("b2b_n_req", n_req, a_req);
        check("b2b_n_en", n_en, a_en);
        check("b2b_n_ov", n_ov, a_ov);
        check("b2b_done_cyc", done_cyc, a_done);

        // Zero rows: clear then done, no column work.
        run_pass(8'd0, 2, n_req, n_en, n_ov, clear_cyc, first_req_cyc, done_cyc, en_bad,
                 final_row, frw);
        check("zero_clear_cyc", clear_cyc, 1);
        check("zero_done_cyc", done_cyc, 2);
        check("zero_n_req", n_req, 0);

        // Fewer rows than the kernel height: no final outputs.
        run_pass(8'd2, 2, n_req, n_en, n_ov, clear_cyc, first_req_cyc, done_cyc, en_bad,
                 final_row, frw);
        check("short_n_req", n_req, 8);
        check("short_n_en", n_en, 4);
        check("short_n_ov", n_ov, 0);
        check("short_done_cyc", done_cyc, 34);
        check("short_final_pos", final_row, 1);

        // Spurious inputs.
        @(negedge clock);
        mac_done = 1'b1;
        @(negedge clock);
        mac_done = 1'b0;
        check("idle_mac_done_ignored", int'(busy), 0);
        start = 1'b1; num_rows = 8'd1;
        @(negedge clock); start = 1'b0;            // CLEAR
        @(negedge clock);                          // ISSUE
        check("spur_issue_req", int'(col_req), 1);
        w0 = width_index;
        mac_done = 1'b1;                           // ignored in ISSUE
        @(negedge clock);
        mac_done = 1'b0;
        start    = 1'b1;                           // ignored while busy
        @(negedge clock);
        start = 1'b0;
        a_req = 0; a_en = 0;
        for (int i = 0; i < 8; i++) begin
            if (col_req) a_req++;
            if (buf_enable || !busy || width_index != w0) a_en++;
            @(negedge clock);
        end
        check("stall_no_req", a_req, 0);
        check("stall_stable", a_en, 0);
        mac_done = 1'b1;
        @(negedge clock);                          // COMMIT
        mac_done = 1'b0;
        @(negedge clock);                          // ISSUE col 1
        check("stall_next_req", int'(col_req), 1);
        check("stall_next_col", int'(width_index), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("spur_reset_outputs", outs_word(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prb_scan_controller.md
Name: prb_scan_controller

Overview:
Sequences one convolution layer pass over the stochastic MAC column and the partial_result_buffer. It walks input rows and columns, drives the buffer's width_index, enable and clear, and handshakes each column computation with the MAC array. It flags which committed columns carry complete output sums. It sits between the layer-level control (start/done) and the MAC/buffer datapath.

Parameters:
INPUT_WIDTH, `INPUT_WIDTH, columns per input row
INPUT_WIDTH_LOG, `INPUT_WIDTH_LOG, width of column index
KERNEL_WIDTH, `KERNEL_WIDTH, kernel columns (>=1, <=INPUT_WIDTH)
KERNEL_HEIGHT, `KERNEL_HEIGHT, kernel rows (>=1)
ROW_W, 8, width of row count/index

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin a pass; sampled only in IDLE
num_rows  in  ROW_W  input rows for this pass; latched on accepted start
mac_done  in  1  MAC array finished current column; sampled only in WAIT
col_req  out  1  one-cycle request to compute column width_index
width_index  out  INPUT_WIDTH_LOG  current column; to buffer and MAC
row_index  out  ROW_W  current input row
buf_clear  out  1  drives buffer reset for one cycle
buf_enable  out  1  buffer store strobe
out_valid  out  1  fetched/stored sums at this commit are final outputs
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset (sync, active-high) or any cycle with reset=1: state=IDLE, row=0, col=0. All outputs 0. Reset mid-pass aborts with no done pulse.
- Outputs are registered state decodes. width_index=col and row_index=row are held stable from ISSUE through COMMIT, because the buffer fetch is combinational on width_index.
- States and transitions:
  - IDLE: start=1 latches num_rows, clears row/col, goes to CLEAR. start=0 stays in IDLE.
  - CLEAR: buf_clear=1 for one cycle. If latched num_rows==0, go to DONE; otherwise go to ISSUE.
  - ISSUE: col_req=1 for one cycle, then WAIT.
  - WAIT: hold until mac_done=1, then COMMIT.
  - COMMIT: buf_enable=(col>=KERNEL_WIDTH-1); out_valid=buf_enable && (row>=KERNEL_HEIGHT-1).
    - If col<INPUT_WIDTH-1: col++, go to ISSUE.
    - Else col=0. If row==num_rows-1, go to DONE; else row++, go to ISSUE.
  - DONE: done=1 for one cycle, then IDLE. row/col remain at their final values until the next start.
- Ignored inputs: mac_done outside WAIT, including in the ISSUE cycle, so the MAC responds no earlier than 1 cycle after col_req. start while busy.
- Rows fewer than KERNEL_HEIGHT: the pass completes normally but out_valid never asserts.
- Per-column cost: 2 + (cycles spent in WAIT). Pass latency from start = 1 (CLEAR) + num_rows*INPUT_WIDTH*per-column cost, then DONE.
- Counters do not wrap. col compares against INPUT_WIDTH-1 exactly. row compares against the latched num_rows-1.
- Assertions: col_req, buf_clear, buf_enable and done are never asserted together. buf_enable implies state==COMMIT.

Decomposition:
- Shared package (sys_defs): state enum {IDLE, CLEAR, ISSUE, WAIT, COMMIT, DONE}; existing `INPUT_WIDTH, `INPUT_WIDTH_LOG, `KERNEL_WIDTH, `KERNEL_HEIGHT.
- One natural sub-module, prb_scan_counter: the col/row nested counter with last_col/last_row flags and an advance strobe.
- The FSM stays in the top module.

Test Plan:
- Reset mid-pass: pulse reset during WAIT -> next cycle IDLE, all outputs 0, no done. A following start runs a full pass.
- Full pass, KW=KH=3, IW=4, num_rows=3, mac_done 2 cycles after each col_req:
  - buf_clear at cycle 1, first col_req at cycle 2.
  - 6 buf_enable pulses (cols 2,3 of each row).
  - 2 out_valid pulses (row 2, cols 2,3).
  - done at cycle 50.
- num_rows=0 -> buf_clear at cycle 1, done at cycle 2, no col_req.
- num_rows=2 with KH=3 -> 8 col_req, 4 buf_enable, 0 out_valid, done asserted.
- Spurious inputs: mac_done pulsed in ISSUE and IDLE, start pulsed during WAIT -> no state change. width_index stays stable across a 10-cycle WAIT stall.
- Back-to-back passes: start asserted in the cycle after done -> second pass identical to the first, with row/col restarting at 0.
